// File: rtl/score_display_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// score_display_pkg : shared segment patterns, FSM states, limits
// Rev 1.0
// ------------------------------------------------------------------
package score_display_pkg;

  // Active-low patterns, bit0=a .. bit6=g
  localparam logic [6:0] c_seg_0     = 7'b1000000;
  localparam logic [6:0] c_seg_1     = 7'b1111001;
  localparam logic [6:0] c_seg_2     = 7'b0100100;
  localparam logic [6:0] c_seg_3     = 7'b0110000;
  localparam logic [6:0] c_seg_4     = 7'b0011001;
  localparam logic [6:0] c_seg_5     = 7'b0010010;
  localparam logic [6:0] c_seg_6     = 7'b0000010;
  localparam logic [6:0] c_seg_7     = 7'b1111000;
  localparam logic [6:0] c_seg_8     = 7'b0000000;
  localparam logic [6:0] c_seg_9     = 7'b0010000;
  localparam logic [6:0] c_seg_blank = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  function automatic logic [63:0] pow10_minus1(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_seg7_decode.sv
`default_nettype none
// ------------------------------------------------------------------
// bcd_seg7_decode : BCD nibble to active-low seven-segment pattern
// Rev 1.0
// ------------------------------------------------------------------
module bcd_seg7_decode
  import score_display_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = c_seg_blank;
    case (i_nibble)
      4'd0: o_seg = c_seg_0;
      4'd1: o_seg = c_seg_1;
      4'd2: o_seg = c_seg_2;
      4'd3: o_seg = c_seg_3;
      4'd4: o_seg = c_seg_4;
      4'd5: o_seg = c_seg_5;
      4'd6: o_seg = c_seg_6;
      4'd7: o_seg = c_seg_7;
      4'd8: o_seg = c_seg_8;
      4'd9: o_seg = c_seg_9;
      default: o_seg = c_seg_blank;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/score_display_scan.sv
`default_nettype none
// ------------------------------------------------------------------
// score_display_scan : binary score -> double-dabble BCD -> scanned
//                      multi-digit seven-segment display
// Rev 1.0
// ------------------------------------------------------------------
module score_display_scan
  import score_display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int BIN_WIDTH    = 16,
  parameter int DWELL_CYCLES = 4,
  parameter int BLINK_CYCLES = 256
)(
  input  logic                  slw_clk,
  input  logic                  rst,
  input  logic [BIN_WIDTH-1:0]  score,
  input  logic                  score_valid,
  output logic                  score_ready,
  input  logic                  blank_lz,
  input  logic                  blink_en,
  output logic                  ovf,
  output logic [NUM_DIGITS-1:0] an_cntrl,
  output logic [6:0]            seg_cntrl
);

  localparam int c_bcd_w   = 4 * NUM_DIGITS;
  localparam int c_cnt_w   = $clog2(BIN_WIDTH + 1);
  localparam int c_dwell_w = $clog2(DWELL_CYCLES + 1);
  localparam int c_idx_w   = $clog2(NUM_DIGITS + 1);
  localparam int c_blink_w = $clog2(BLINK_CYCLES + 1);
  localparam logic [63:0]        c_ovf_limit = pow10_minus1(NUM_DIGITS);
  localparam logic [c_bcd_w-1:0] c_all_nines = {NUM_DIGITS{4'h9}};

  state_t               r_state;
  logic                 r_ready;
  logic                 r_ovf;
  logic                 r_ovf_pend;
  logic [BIN_WIDTH-1:0] r_shift;
  logic [c_bcd_w-1:0]   r_bcd;
  logic [c_bcd_w-1:0]   r_buf;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_bcd_w-1:0]   w_bcd_adj;

  logic [c_dwell_w-1:0] r_dwell;
  logic [c_idx_w-1:0]   r_idx;
  logic [c_blink_w-1:0] r_blink_cnt;
  logic                 r_blink_on;

  logic [NUM_DIGITS-1:0] w_lz;
  logic [NUM_DIGITS-1:0] w_an_sel;
  logic [3:0]            w_nib;
  logic                  w_blanked;
  logic [6:0]            w_seg;

  assign score_ready = r_ready;
  assign ovf         = r_ovf;

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge slw_clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ready    <= 1'b1;
      r_ovf      <= 1'b0;
      r_ovf_pend <= 1'b0;
      r_shift    <= '0;
      r_bcd      <= '0;
      r_buf      <= '0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (score_valid && r_ready) begin
            r_shift    <= score;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= (64'(score) > c_ovf_limit);
            r_ready    <= 1'b0;
            r_state    <= ST_CONV;
          end
        end
        ST_CONV: begin
          // Top bit of the adjusted value is shifted out; overflowed scores saturate at commit.
          r_bcd   <= (w_bcd_adj << 1) | c_bcd_w'(r_shift[BIN_WIDTH-1]);
          r_shift <= r_shift << 1;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == c_cnt_w'(BIN_WIDTH - 1)) r_state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          r_buf   <= r_ovf_pend ? c_all_nines : r_bcd;
          r_ovf   <= r_ovf_pend;
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge slw_clk or posedge rst) begin
    if (rst) begin
      r_dwell     <= '0;
      r_idx       <= '0;
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else begin
      if (r_dwell == c_dwell_w'(DWELL_CYCLES - 1)) begin
        r_dwell <= '0;
        r_idx   <= (r_idx == c_idx_w'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
      end else begin
        r_dwell <= r_dwell + 1'b1;
      end
      if (r_blink_cnt == c_blink_w'(BLINK_CYCLES - 1)) begin
        r_blink_cnt <= '0;
        r_blink_on  <= ~r_blink_on;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  // w_lz[i] is set when digit i and every digit above it are zero
  always_comb begin
    logic v_zero;
    v_zero = 1'b1;
    w_lz   = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      v_zero = v_zero & (r_buf[4*i +: 4] == 4'd0);
      w_lz[i] = v_zero;
    end
  end

  always_comb begin
    w_nib     = '0;
    w_blanked = 1'b0;
    w_an_sel  = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == c_idx_w'(i)) begin
        w_nib       = r_buf[4*i +: 4];
        w_blanked   = blank_lz && (i != 0) && w_lz[i];
        w_an_sel[i] = 1'b0;
      end
    end
  end

  bcd_seg7_decode u_dec (
    .i_nibble (w_nib),
    .o_seg    (w_seg)
  );

  assign an_cntrl  = (w_blanked || (blink_en && !r_blink_on)) ? '1 : w_an_sel;
  assign seg_cntrl = w_blanked ? c_seg_blank : w_seg;

endmodule
`default_nettype wire

// File: doc/score_display_scan.md
Name: score_display_scan

Overview:
- Parametrised multi-digit seven-segment score display controller.
- Accepts a binary score over a valid/ready handshake.
- Converts the score to BCD with a sequential shift-add-3 (double-dabble) engine, then latches it into a display buffer.
- Time-multiplexes NUM_DIGITS active-low digits, with configurable dwell, leading-zero blanking, overflow saturation and blink. Sits between game scoring logic and the board's anode/segment pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (1..8)
- BIN_WIDTH, 16, width of binary score input
- DWELL_CYCLES, 4, slw_clk cycles each digit stays lit (>=1)
- BLINK_CYCLES, 256, slw_clk cycles per blink half-period (>=1)

Ports:
- slw_clk  in  1  scan/conversion clock
- rst  in  1  asynchronous active-high reset
- score  in  BIN_WIDTH  binary score value
- score_valid  in  1  score offered
- score_ready  out  1  converter idle; score is accepted when valid && ready
- blank_lz  in  1  blank leading zeros
- blink_en  in  1  blink entire display
- ovf  out  1  last committed score exceeded 10^NUM_DIGITS-1
- an_cntrl  out  NUM_DIGITS  anodes, active low, one-hot-zero
- seg_cntrl  out  7  segments, active low, bit0=a .. bit6=g

Behaviour:
- Reset is asynchronous, active-high; clock slw_clk.
- Reset values:
  - FSM in IDLE; score_ready=1; ovf=0.
  - Buffer all zeros; digit index 0; dwell counter 0; blink phase ON; blink counter 0.
  - Result: an_cntrl has only bit0 low; seg_cntrl = 7'b1000000 ("0").
- FSM states:
  - IDLE: score_ready=1. On valid && ready, capture score into a shift register, clear the BCD accumulator, compute ovf_pending = (score > 10^NUM_DIGITS-1), and go to CONV.
  - CONV: score_ready=0. Each cycle: add 3 to every BCD nibble >=5, then shift left one bit, pulling in the shift-register MSB. A counter counts BIN_WIDTH cycles, then the FSM goes to COMMIT.
  - COMMIT: score_ready=0. Write the buffer (all nibbles 9 if ovf_pending, else the BCD result), set ovf=ovf_pending, go to IDLE.
- Timing:
  - score_ready is low for exactly BIN_WIDTH+1 cycles after acceptance.
  - The new value appears on the display the cycle after COMMIT.
  - score/score_valid are ignored while busy; no queuing.
- The buffer holds its old value throughout conversion, so the display never shows partial BCD.
- Scan:
  - The dwell counter counts 0..DWELL_CYCLES-1.
  - On wrap, the digit index increments 0..NUM_DIGITS-1 and then wraps to 0.
  - Digit 0 is the least significant digit, driving an_cntrl[0].
- Leading-zero blanking: when blank_lz=1, digit i>0 is blanked if it and all higher digits are 0. Digit 0 is never blanked. A blanked digit drives its anode high and seg_cntrl=7'h7F.
- Blink:
  - The blink counter runs continuously and toggles phase every BLINK_CYCLES.
  - When blink_en=1 and phase is OFF, an_cntrl is all ones.
  - When blink_en=0, the display is always lit; the counter keeps running.
- Output decode: an_cntrl and seg_cntrl are combinational from registered state (buffer, index, phase, inputs blank_lz/blink_en). Non-decimal nibbles (unreachable) decode to 7'h7F.
- Reset mid-CONV aborts the conversion, clears the buffer and returns to IDLE.

Decomposition:
- Package score_display_pkg holds:
  - seven-segment pattern constants for 0-9 and blank (active low)
  - state enum IDLE/CONV/COMMIT
  - function pow10_minus1(n) for the overflow limit.
- Sub-module bcd_seg7_decode: 4-bit nibble in, 7-bit active-low pattern out, combinational. It is instantiated once and fed by the scan mux.
- Double-dabble and scan logic stay in the top module.

Test Plan:
- Reset, no stimulus -> an_cntrl=4'b1110, seg_cntrl=7'b1000000; score_ready=1; ovf=0.
- Accept score=16'd1234 -> score_ready low 17 cycles. Then digits 0..3 show 4,3,2,1 (seg 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001). Each digit holds 4 cycles, and anodes rotate 1110→1101→1011→0111→1110.
- score=16'd12345 (> 9999) -> ovf=1, all digits show 9 (7'b0010000). A following score=16'd7 -> ovf=0.
- blank_lz=1, score=16'd7 -> only an_cntrl[0] ever goes low, showing 7'b1111000. score=0 -> digit 0 shows "0".
- blink_en=1 with BLINK_CYCLES=8 -> an_cntrl is all ones for 8 cycles and scanning for 8 cycles, alternating. Offering score_valid during CONV -> ignored, buffer unchanged.
- Assert rst at CONV cycle 5 after accepting 1234 -> outputs return to reset values immediately. After release, score_ready=1 and the buffer is 0.
